// File: rtl/cofactor_pkg.sv
// Shared defaults for the cofactor datapath stages so that producers, the FIFO
// and the downstream consumers all agree on RAM geometry and word width.
package cofactor_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage : cofactor_pkg

// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read.
module ram #(
  parameter int mem_width  = 16,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [addr_width-1:0] write_address,
  input  logic [mem_width-1:0]  write_data,
  input  logic                  read_en,
  input  logic [addr_width-1:0] read_address,
  output logic [mem_width-1:0]  read_data
);

  logic [mem_width-1:0] mem [2**addr_width];

  // NOTE: storage has no reset so it maps onto RAM macros; nothing reads a
  // location before the write pointer has filled it.
  always_ff @(posedge clk) begin
    if (write_en) mem[write_address] <= write_data;
    if (read_en)  read_data <= mem[read_address];
  end

endmodule : ram

// File: rtl/ram_stream_fifo.sv
// Valid/ready FIFO around the RAM: the registered read latency is hidden by a
// 2-entry output buffer (head + skid) fed by a single in-flight read.
module ram_stream_fifo
  import cofactor_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int                CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH = CW'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         ram_cnt;
  logic                  inflight;
  logic                  head_v, skid_v;
  logic [DATA_WIDTH-1:0] head_d, skid_d;
  logic [DATA_WIDTH-1:0] read_data;

  logic                  push, pop, issue;
  logic [1:0]            occ;
  logic                  head_v_n, skid_v_n;
  logic [DATA_WIDTH-1:0] head_d_n, skid_d_n;

  assign in_ready  = (ram_cnt < DEPTH);
  assign push      = in_valid & in_ready;
  assign pop       = head_v & out_ready;
  assign out_valid = head_v;
  assign out_data  = head_d;

  // Slots already claimed downstream of the RAM. A pop this cycle frees its
  // slot in time for the issued word, which is what sustains 1 word/cycle.
  assign occ   = 2'(head_v) + 2'(skid_v) + 2'(inflight);
  assign issue = (ram_cnt != '0) && ((occ - 2'(pop)) < 2'd2);

  ram #(
    .mem_width (DATA_WIDTH),
    .addr_width(ADDR_WIDTH)
  ) u_ram (
    .clk          (clk),
    .write_en     (push),
    .write_address(wr_ptr),
    .write_data   (in_data),
    .read_en      (issue),
    .read_address (rd_ptr),
    .read_data    (read_data)
  );

  // Pop shifts skid into head; a returning read then fills the first free slot.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    head_v_n = head_v;
    head_d_n = head_d;
    skid_v_n = skid_v;
    skid_d_n = skid_d;
    if (pop) begin
      head_v_n = skid_v;
      if (skid_v) head_d_n = skid_d;
      skid_v_n = 1'b0;
    end
    if (inflight) begin
      if (!head_v_n) begin
        head_v_n = 1'b1;
        head_d_n = read_data;
      end else begin
        skid_v_n = 1'b1;
        skid_d_n = read_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      head_v   <= 1'b0;
      skid_v   <= 1'b0;
      head_d   <= '0;
      skid_d   <= '0;
      level    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt  <= ram_cnt + CW'(push) - CW'(issue);
      level    <= level + CW'(push) - CW'(pop);
      inflight <= issue;
      head_v   <= head_v_n;
      head_d   <= head_d_n;
      skid_v   <= skid_v_n;
      skid_d   <= skid_d_n;
    end
  end

endmodule : ram_stream_fifo
